// File: rtl/pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl
//   Hazard controller for a 5-stage pipeline. It holds the front stages on a
//   load-use dependency, squashes the two younger instructions on a taken
//   branch/jump, and holds the pipeline while a multi-cycle mul/div op
//   occupies EXE. It also keeps a saturating count of PC stall cycles.
//
// Handshake / timing: every stall/flush control is combinational from the
//   current FSM state and the current-cycle inputs. The FSM state, md_cnt and
//   stall_cnt update on the rising edge of clk.
//
// Parameters
//   MD_LAT        total EXE occupancy (cycles) of a mul/div op, 2..16
// Ports
//   clk           clock, rising edge
//   rst           synchronous reset, active low
//   IFID_rs/rt    source registers of the instruction in ID
//   use_rs/rt     ID instruction actually reads rs / rt
//   IDEXE_DMRd    load type of the EXE instruction (0 = not a load)
//   IDEXE_rd      destination register of the EXE instruction
//   branch_taken  taken branch/jump resolved in EXE
//   md_start      mul/div op entering EXE this cycle
//   PC_stall .. EXEMEM_flush   stage hold / bubble controls
//   md_busy       FSM is in BUSY
//   md_done       pulse in the last cycle of a mul/div op
//   stall_cnt     saturating count of cycles with PC_stall high
// ---------------------------------------------------------------------------
module pipe_hazard_ctrl #(
    parameter int MD_LAT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  IFID_rs,
    input  logic [4:0]  IFID_rt,
    input  logic        use_rs,
    input  logic        use_rt,
    input  logic [3:0]  IDEXE_DMRd,
    input  logic [4:0]  IDEXE_rd,
    input  logic        branch_taken,
    input  logic        md_start,
    output logic        PC_stall,
    output logic        IFID_stall,
    output logic        IFID_flush,
    output logic        IDEXE_stall,
    output logic        IDEXE_flush,
    output logic        EXEMEM_flush,
    output logic        md_busy,
    output logic        md_done,
    output logic [15:0] stall_cnt
);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    // The start cycle and the final (md_cnt == 0) cycle are both part of
    // MD_LAT, so BUSY lasts MD_LAT-1 cycles.
    localparam logic [3:0] MD_LOAD = 4'(MD_LAT - 2);

    state_t     state;
    logic [3:0] md_cnt;
    logic       load_use;
    logic       md_go;

    // A write to r0 never creates a dependency.
    assign load_use = (IDEXE_DMRd != 4'b0000) && (IDEXE_rd != 5'd0) &&
                      ((use_rs && (IFID_rs == IDEXE_rd)) ||
                       (use_rt && (IFID_rt == IDEXE_rd)));

    assign md_go = (state == IDLE) && md_start && !branch_taken;

    // Priority: reset, then BUSY, then branch, then mul/div start, then load-use.
    always_comb begin
        PC_stall     = 1'b0;
        IFID_stall   = 1'b0;
        IFID_flush   = 1'b0;
        IDEXE_stall  = 1'b0;
        IDEXE_flush  = 1'b0;
        EXEMEM_flush = 1'b0;
        md_busy      = 1'b0;
        md_done      = 1'b0;
        if (rst) begin
            if (state == BUSY) begin
                PC_stall     = 1'b1;
                IFID_stall   = 1'b1;
                IDEXE_stall  = 1'b1;
                // Result leaves EXE only in the final cycle; bubbles before that.
                EXEMEM_flush = (md_cnt != 4'd0);
                md_done      = (md_cnt == 4'd0);
                md_busy      = 1'b1;
            end else if (branch_taken) begin
                IFID_flush   = 1'b1;
                IDEXE_flush  = 1'b1;
            end else if (md_start) begin
                PC_stall     = 1'b1;
                IFID_stall   = 1'b1;
                IDEXE_stall  = 1'b1;
                EXEMEM_flush = 1'b1;
            end else if (load_use) begin
                PC_stall     = 1'b1;
                IFID_stall   = 1'b1;
                IDEXE_flush  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            md_cnt    <= 4'd0;
            stall_cnt <= 16'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (md_go) begin
                        state  <= BUSY;
                        md_cnt <= MD_LOAD;
                    end
                end
                BUSY: begin
                    if (md_cnt == 4'd0) begin
                        state <= IDLE;
                    end else begin
                        md_cnt <= md_cnt - 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
            if (PC_stall && (stall_cnt != 16'hFFFF)) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
//   Self-checking bench for pipe_hazard_ctrl (MD_LAT = 4). Each cycle the
//   drive task applies inputs just after the rising edge and pushes the
//   expected {controls, stall_cnt} word; the scenario task pops it and
//   compares against the DUT on the falling edge.
//   Expected control word bit order:
//   {PC_stall, IFID_stall, IFID_flush, IDEXE_stall, IDEXE_flush,
//    EXEMEM_flush, md_busy, md_done}
// ---------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

    localparam logic [7:0] E_NONE   = 8'b0000_0000;
    localparam logic [7:0] E_LU     = 8'b1100_1000;
    localparam logic [7:0] E_BR     = 8'b0010_1000;
    localparam logic [7:0] E_MD0    = 8'b1101_0100;
    localparam logic [7:0] E_BUSY   = 8'b1101_0110;
    localparam logic [7:0] E_DONE   = 8'b1101_0011;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [4:0]  IFID_rs = '0, IFID_rt = '0, IDEXE_rd = '0;
    logic        use_rs = 1'b0, use_rt = 1'b0;
    logic [3:0]  IDEXE_DMRd = '0;
    logic        branch_taken = 1'b0, md_start = 1'b0;
    logic        PC_stall, IFID_stall, IFID_flush, IDEXE_stall;
    logic        IDEXE_flush, EXEMEM_flush, md_busy, md_done;
    logic [15:0] stall_cnt;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.MD_LAT(4)) dut (
        .clk(clk), .rst(rst),
        .IFID_rs(IFID_rs), .IFID_rt(IFID_rt),
        .use_rs(use_rs), .use_rt(use_rt),
        .IDEXE_DMRd(IDEXE_DMRd), .IDEXE_rd(IDEXE_rd),
        .branch_taken(branch_taken), .md_start(md_start),
        .PC_stall(PC_stall), .IFID_stall(IFID_stall), .IFID_flush(IFID_flush),
        .IDEXE_stall(IDEXE_stall), .IDEXE_flush(IDEXE_flush),
        .EXEMEM_flush(EXEMEM_flush), .md_busy(md_busy), .md_done(md_done),
        .stall_cnt(stall_cnt)
    );

    logic [23:0] obs;
    assign obs = {PC_stall, IFID_stall, IFID_flush, IDEXE_stall, IDEXE_flush,
                  EXEMEM_flush, md_busy, md_done, stall_cnt};

    // ---------------- scoreboard ----------------
    logic [23:0] exp_q[$];
    logic [15:0] exp_cnt = 16'd0;
    int          n_tests = 0;
    int          n_fail  = 0;

    // ---------------- driver ----------------
    // Applies one cycle of inputs, queues the expectation, and returns at the
    // falling edge of that cycle. stall_cnt seen now reflects earlier cycles.
    task automatic drive(input logic r, input logic [4:0] rs, input logic [4:0] rt,
                         input logic urs, input logic urt, input logic [3:0] dmrd,
                         input logic [4:0] rd, input logic bt, input logic mds,
                         input logic [7:0] e);
        @(posedge clk);
        #1;
        rst = r; IFID_rs = rs; IFID_rt = rt; use_rs = urs; use_rt = urt;
        IDEXE_DMRd = dmrd; IDEXE_rd = rd; branch_taken = bt; md_start = mds;
        exp_q.push_back({e, exp_cnt});
        if (!r) exp_cnt = 16'd0;
        else if (e[7] && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
        @(negedge clk);
    endtask

    task automatic idle_cycle();
        drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 4'd0, 5'd0, 1'b0, 1'b0, E_NONE);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [23:0] e;
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 5'd7, 5'd7, 1'b1, 1'b1, 4'b0001, 5'd7, i[0], ~i[0], E_NONE);
            e = exp_q.pop_front(); n_tests++;
            if (i > 0 && obs !== e) begin
                n_fail++; $display("FAIL reset[%0d]: got %h exp %h", i, obs, e);
            end
        end
        idle_cycle();
        e = exp_q.pop_front(); n_tests++;
        if (obs !== e) begin n_fail++; $display("FAIL reset_release: got %h exp %h", obs, e); end
    endtask

    task automatic test_load_use();
        logic [23:0] e;
        drive(1'b1, 5'd5, 5'd9, 1'b1, 1'b0, 4'b0001, 5'd5, 1'b0, 1'b0, E_LU);
        e = exp_q.pop_front(); n_tests++;
        if (obs !== e) begin n_fail++; $display("FAIL load_use_rs: got %h exp %h", obs, e); end
        idle_cycle();
        e = exp_q.pop_front(); n_tests++;
        if (obs !== e) begin n_fail++; $display("FAIL load_use_after: got %h exp %h", obs, e); end
        // rt path with randomized registers
        for (int i = 0; i < 4; i++) begin
            logic [4:0] r, o;
            r = 5'($urandom_range(1, 31));
            o = (r == 5'd31) ? 5'd1 : r + 5'd1;
            drive(1'b1, o, r, 1'b1, 1'b1, 4'($urandom_range(1, 15)), r, 1'b0, 1'b0, E_LU);
            e = exp_q.pop_front(); n_tests++;
            if (obs !== e) begin n_fail++; $display("FAIL load_use_rt[%0d]: got %h exp %h", i, obs, e); end
        end
    endtask

    task automatic test_no_hazard();
        logic [23:0] e;
        // rd == 0
        drive(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 4'b0001, 5'd0, 1'b0, 1'b0, E_NONE);
        e = exp_q.pop_front(); n_tests++;
        if (obs !== e) begin n_fail++; $display("FAIL no_hazard_rd0: got %h exp %h", obs, e); end
        // register matches but is not read
        drive(1'b1, 5'd5, 5'd5, 1'b0, 1'b0, 4'b0001, 5'd5, 1'b0, 1'b0, E_NONE);
        e = exp_q.pop_front(); n_tests++;
        if (obs !== e) begin n_fail++; $display("FAIL no_hazard_unused: got %h exp %h", obs, e); end
        // not a load
        drive(1'b1, 5'd5, 5'd5, 1'b1, 1'b1, 4'b0000, 5'd5, 1'b0, 1'b0, E_NONE);
        e = exp_q.pop_front(); n_tests++;
        if (obs !== e) begin n_fail++; $display("FAIL no_hazard_noload: got %h exp %h", obs, e); end
        // random mismatching registers
        for (int i = 0; i < 4; i++) begin
            logic [4:0] r, o;
            r = 5'($urandom_range(1, 30));
            o = r + 5'd1;
            drive(1'b1, o, o, 1'b1, 1'b1, 4'b0010, r, 1'b0, 1'b0, E_NONE);
            e = exp_q.pop_front(); n_tests++;
            if (obs !== e) begin n_fail++; $display("FAIL no_hazard_diff[%0d]: got %h exp %h", i, obs, e); end
        end
    endtask

    task automatic test_muldiv();
        logic [23:0] e;
        logic [7:0]  seq[5];
        seq = '{E_MD0, E_BUSY, E_BUSY, E_DONE, E_LU};
        for (int i = 0; i < 5; i++) begin
            // during BUSY, branch and load-use are presented and must be ignored;
            // in the first IDLE cycle afterwards load-use must be honoured.
            drive(1'b1, 5'd6, 5'd0, 1'b1, 1'b0, 4'b0001, 5'd6,
                  (i == 1 || i == 2) ? 1'b1 : 1'b0, (i == 0 || i == 2) ? 1'b1 : 1'b0, seq[i]);
            e = exp_q.pop_front(); n_tests++;
            if (obs !== e) begin n_fail++; $display("FAIL muldiv[N+%0d]: got %h exp %h", i, obs, e); end
        end
        idle_cycle();
        e = exp_q.pop_front(); n_tests++;
        if (obs !== e) begin n_fail++; $display("FAIL muldiv_end: got %h exp %h", obs, e); end
    endtask

    task automatic test_branch();
        logic [23:0] e;
        drive(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 4'b0001, 5'd5, 1'b1, 1'b1, E_BR);
        e = exp_q.pop_front(); n_tests++;
        if (obs !== e) begin n_fail++; $display("FAIL branch_prio: got %h exp %h", obs, e); end
        idle_cycle();
        e = exp_q.pop_front(); n_tests++;
        if (obs !== e) begin n_fail++; $display("FAIL branch_stay_idle: got %h exp %h", obs, e); end
    endtask

    task automatic test_reset_in_busy();
        logic [23:0] e;
        logic [7:0]  seq[4];
        seq = '{E_MD0, E_BUSY, E_NONE, E_NONE};
        for (int i = 0; i < 4; i++) begin
            drive((i == 2) ? 1'b0 : 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 4'd0, 5'd0,
                  1'b0, (i == 0) ? 1'b1 : 1'b0, seq[i]);
            e = exp_q.pop_front(); n_tests++;
            if (obs !== e) begin n_fail++; $display("FAIL reset_busy[N+%0d]: got %h exp %h", i, obs, e); end
        end
    endtask

    task automatic test_saturation();
        logic [23:0] e;
        drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 4'd0, 5'd0, 1'b0, 1'b0, E_NONE);
        void'(exp_q.pop_front());
        for (int i = 0; i < 65540; i++) begin
            drive(1'b1, 5'd3, 5'd0, 1'b1, 1'b0, 4'b0100, 5'd3, 1'b0, 1'b0, E_LU);
            e = exp_q.pop_front();
            if (i == 0 || i == 65533 || i == 65535 || i == 65539) begin
                n_tests++;
                if (obs !== e) begin n_fail++; $display("FAIL saturate[%0d]: got %h exp %h", i, obs, e); end
            end
        end
        idle_cycle();
        e = exp_q.pop_front(); n_tests++;
        if (obs !== e || stall_cnt !== 16'hFFFF) begin
            n_fail++; $display("FAIL saturate_hold: got %h exp %h", obs, e);
        end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        test_reset();
        test_load_use();
        test_no_hazard();
        test_muldiv();
        test_branch();
        test_reset_in_busy();
        test_saturation();
        if (exp_q.size() != 0) begin
            n_fail++; $display("FAIL scoreboard_left: got %0d entries exp 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
